// File: rtl/uart_tx_framer_if.sv
// Byte handshake between a producer and the UART transmit framer.
interface uart_tx_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop
// framer that is paced by an external baud generator it enables itself.
module uart_tx_framer #(
    parameter int FifoDepth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_tx_framer_if.slave              in_if,
    output logic                         baud_enable,
    input  logic                         baud_tick,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FifoDepth):0]   fifo_count
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [FifoDepth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              baud_en_q, baud_en_d;
    logic              push, pop, fifo_empty;

    // No bypass: a full FIFO refuses a byte even while a pop is in flight.
    assign in_if.in_ready = (count_q < CntW'(FifoDepth));
    assign push           = in_if.in_valid && in_if.in_ready;
    assign fifo_empty     = (count_q == '0);

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: every transition after IDLE is paced by baud ticks.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_WAIT;
            S_WAIT:  if (baud_tick) state_d = S_START;
            S_START: if (baud_tick) state_d = S_DATA;
            S_DATA:  if (baud_tick && idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (baud_tick) state_d = fifo_empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: line level, shifter, bit index, pop and baud enable.
    always_comb begin
        pop       = 1'b0;
        tx_d      = tx_q;
        baud_en_d = baud_en_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    baud_en_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (baud_tick) tx_d = 1'b0;
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (idx_q != 3'd7) begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    // Chain straight into the next start bit when data waits,
                    // keeping the generator running so frames abut.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                    end else begin
                        baud_en_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write.
    // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    // Pointers, count and framer datapath; reset aborts a frame and idles the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            baud_en_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q   <= count_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            baud_en_q <= baud_en_d;
        end
    end

    assign tx          = tx_q;
    assign baud_enable = baud_en_q;
    assign busy        = (state_q != S_IDLE);
    assign fifo_count  = count_q;

endmodule
